diff_freq_serial_tx: RTL and testbench
======================================

Name: diff_freq_serial_tx

Overview:
- Per-channel serialiser downstream of the UART command decoder.
- Consumes a decoded command: output pattern, frequency pattern, start, stop, mode and channel select. It shifts the output pattern out LSB-first on one pin.
- Each bit is held for a fast or slow period, chosen per bit by the frequency pattern.
- One instance per output channel; an instance accepts only commands whose select matches CHANNEL_ID.

Parameters:
- DATA_BIT, 32, width of output and frequency patterns (bits per frame).
- FAST_DIV, 4, clock cycles per bit when freq bit = 1; must be ≥ 1.
- SLOW_DIV, 16, clock cycles per bit when freq bit = 0; must be ≥ 1.
- CHANNEL_ID, 0, select value (0..15) this instance responds to.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low
- i_load_tick  input  1  one-cycle command-valid strobe from the decoder
- i_output_pattern  input  DATA_BIT  serial data; bit 0 is sent first
- i_freq_pattern  input  DATA_BIT  per-bit speed; 1 = FAST_DIV, 0 = SLOW_DIV
- i_sel_out  input  4  target channel of the command
- i_start  input  1  begin transmission
- i_stop  input  1  abort / stop channel
- i_mode  input  1  0 = one-shot frame, 1 = continuous repeat
- o_serial  output  1  serial output
- o_busy  output  1  high while in S_RUN
- o_bit_index  output  clog2(DATA_BIT)  index of the bit currently driven
- o_done_tick  output  1  one-cycle pulse when a one-shot frame completes

Behaviour:
- Command acceptance: accepted = i_load_tick && (i_sel_out == CHANNEL_ID). Non-matching ticks are ignored entirely.
- Reset (rst_n = 0 at a clk edge): state = S_IDLE. o_serial, o_busy, o_bit_index and o_done_tick are 0. Active registers, shadow registers, pending flag and cycle counter are cleared. Reset mid-frame aborts the frame with no done tick.
- Registers:
  - Active set: pattern, freq, mode.
  - Shadow set: pattern, freq, mode, pending flag.
  - Bit index.
  - Cycle counter, width clog2(max(FAST_DIV, SLOW_DIV)).
- States: S_IDLE, S_ARMED, S_RUN, S_DONE. o_serial is registered.
- S_IDLE:
  - o_serial = 0.
  - Accepted with stop = 1: stay in S_IDLE.
  - Accepted with start = 1: load active set, index = 0, counter = 0, go to S_RUN. o_serial = pattern[0] and o_busy = 1 on the next cycle (1-cycle latency).
  - Accepted with start = 0, stop = 0: load active set, go to S_ARMED.
- S_ARMED:
  - o_serial = 0.
  - Accepted with stop = 1: go to S_IDLE.
  - Accepted with start = 0: overwrite active set.
  - Accepted with start = 1: load the new command and go to S_RUN as from S_IDLE.
- S_RUN:
  - o_serial = active_pattern[index].
  - Bit period = FAST_DIV if active_freq[index] else SLOW_DIV. The counter increments each cycle; at period-1 it resets to 0 and index advances.
  - End of frame = last cycle of bit DATA_BIT-1:
    - pending = 1: copy shadow to active, clear pending, index = 0, continue with no idle gap.
    - else mode = 1: index wraps to 0, continue.
    - else mode = 0: go to S_DONE.
  - Accepted with stop = 1: go to S_IDLE next cycle (o_serial = 0, o_busy = 0), clear pending, no done tick. Stop has priority over start and over a simultaneous end of frame.
  - Accepted with stop = 0 (start ignored): write shadow and set pending. A later command overwrites the shadow; last one wins.
  - A command accepted on the end-of-frame cycle is taken directly as the next frame.
- S_DONE:
  - o_done_tick = 1 for exactly one cycle; o_serial = 0; o_busy = 0.
  - Next state is S_IDLE.
  - Accepted with start = 1 in S_DONE is handled as in S_IDLE (loads and runs).
- Frame length: sum over bits of period (FAST_DIV or SLOW_DIV).
  - All-ones freq: DATA_BIT × FAST_DIV cycles.
  - All-zeros freq: DATA_BIT × SLOW_DIV cycles.
- o_bit_index equals the index of the bit on o_serial; it is 0 outside S_RUN.

Test Plan (DATA_BIT = 8, FAST_DIV = 2, SLOW_DIV = 4, CHANNEL_ID = 1):
- One-shot:
  - Stimulus: load sel = 1, pattern = 0xA5, freq = 0x0F, start = 1, mode = 0.
  - Response: o_serial sequence 1,1,0,0,1,1,0,0 then 0×4, 1×4, 0×4, 1×4 (24 cycles, starting 1 cycle after the tick). o_done_tick pulses on cycle 25, then o_busy = 0.
- Channel filter:
  - Stimulus: load sel = 2, start = 1.
  - Response: no state change, o_busy stays 0, o_serial stays 0.
- Continuous with queued update:
  - Stimulus: mode = 1, pattern = 0xFF, freq = 0xFF. Mid-frame, load pattern = 0x00, mode = 0.
  - Response: the first frame completes (16 cycles of 1). The next 16 cycles are 0 with no gap, then one done tick.
- Stop:
  - Stimulus: stop = 1 at bit 3 of a running frame, issued simultaneously with start = 1.
  - Response: o_serial = 0 and o_busy = 0 the next cycle, no done tick, pending cleared.
- Armed start:
  - Stimulus: load start = 0, pattern = 0x01; 10 idle cycles; then load start = 1, pattern = 0x80, freq = 0x00.
  - Response: o_serial = 0 while armed. Frame = 28 cycles 0 then 4 cycles 1.
- Reset mid-frame:
  - Stimulus: rst_n = 0 for 1 cycle during bit 5.
  - Response: all outputs 0 after the edge. A subsequent load starts cleanly from bit 0.

Source files
------------

// File: rtl/diff_freq_serial_tx.sv
// rtl/diff_freq_serial_tx.sv - per-channel serialiser with per-bit fast/slow bit periods
//
// Shifts a DATA_BIT-wide output pattern out LSB-first on o_serial. Each bit is
// held for FAST_DIV cycles when its frequency-pattern bit is 1, else SLOW_DIV.
// Only commands whose i_sel_out equals CHANNEL_ID are accepted.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   i_load_tick        one-cycle command-valid strobe
//   i_output_pattern   serial data, bit 0 first
//   i_freq_pattern     per-bit speed select (1 = FAST_DIV, 0 = SLOW_DIV)
//   i_sel_out          target channel of the command
//   i_start, i_stop    begin / abort transmission
//   i_mode             0 = one-shot frame, 1 = continuous repeat
//   o_serial           registered serial output
//   o_busy             high while a frame is running
//   o_bit_index        index of the bit currently on o_serial (0 when not running)
//   o_done_tick        one-cycle pulse when a one-shot frame completes
module diff_freq_serial_tx #(
  parameter int DATA_BIT   = 32,
  parameter int FAST_DIV   = 4,
  parameter int SLOW_DIV   = 16,
  parameter int CHANNEL_ID = 0,
  localparam int IDX_W     = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_load_tick,
  input  logic [DATA_BIT-1:0] i_output_pattern,
  input  logic [DATA_BIT-1:0] i_freq_pattern,
  input  logic [3:0]          i_sel_out,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic                i_mode,
  output logic                o_serial,
  output logic                o_busy,
  output logic [IDX_W-1:0]    o_bit_index,
  output logic                o_done_tick
);

  localparam int MAX_DIV = (FAST_DIV > SLOW_DIV) ? FAST_DIV : SLOW_DIV;
  localparam int CNT_W   = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;

  localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_DIV - 1);
  localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_BIT-1:0] act_pattern_q, act_pattern_d;
  logic [DATA_BIT-1:0] act_freq_q, act_freq_d;
  logic                act_mode_q, act_mode_d;
  logic [DATA_BIT-1:0] shd_pattern_q, shd_pattern_d;
  logic [DATA_BIT-1:0] shd_freq_q, shd_freq_d;
  logic                shd_mode_q, shd_mode_d;
  logic                pending_q, pending_d;
  logic [IDX_W-1:0]    index_q, index_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                serial_q, serial_d;

  logic                accepted;
  logic                bit_last;
  logic                frame_last;

  assign accepted   = i_load_tick && (i_sel_out == 4'(CHANNEL_ID));
  assign bit_last   = (cnt_q == (act_freq_q[index_q] ? FAST_LAST : SLOW_LAST));
  assign frame_last = bit_last && (index_q == IDX_LAST);

  always_comb begin
    state_d       = state_q;
    act_pattern_d = act_pattern_q;
    act_freq_d    = act_freq_q;
    act_mode_d    = act_mode_q;
    shd_pattern_d = shd_pattern_q;
    shd_freq_d    = shd_freq_q;
    shd_mode_d    = shd_mode_q;
    pending_d     = pending_q;
    index_d       = index_q;
    cnt_d         = cnt_q;
    serial_d      = 1'b0;

    case (state_q)
      // S_DONE behaves like S_IDLE for commands; its only job is the done pulse.
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        index_d = '0;
        cnt_d   = '0;
        if (accepted && !i_stop) begin
          act_pattern_d = i_output_pattern;
          act_freq_d    = i_freq_pattern;
          act_mode_d    = i_mode;
          state_d       = i_start ? S_RUN : S_ARMED;
        end
      end

      S_ARMED: begin
        if (accepted) begin
          if (i_stop) begin
            state_d = S_IDLE;
          end else begin
            act_pattern_d = i_output_pattern;
            act_freq_d    = i_freq_pattern;
            act_mode_d    = i_mode;
            index_d       = '0;
            cnt_d         = '0;
            if (i_start) state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (accepted && i_stop) begin
          // Abort wins over start and over a coincident end of frame.
          state_d   = S_IDLE;
          pending_d = 1'b0;
          index_d   = '0;
          cnt_d     = '0;
        end else if (frame_last) begin
          index_d = '0;
          cnt_d   = '0;
          if (accepted) begin
            // A command landing on the final cycle becomes the next frame directly.
            act_pattern_d = i_output_pattern;
            act_freq_d    = i_freq_pattern;
            act_mode_d    = i_mode;
            pending_d     = 1'b0;
          end else if (pending_q) begin
            act_pattern_d = shd_pattern_q;
            act_freq_d    = shd_freq_q;
            act_mode_d    = shd_mode_q;
            pending_d     = 1'b0;
          end else if (!act_mode_q) begin
            state_d = S_DONE;
          end
        end else begin
          if (accepted) begin
            shd_pattern_d = i_output_pattern;
            shd_freq_d    = i_freq_pattern;
            shd_mode_d    = i_mode;
            pending_d     = 1'b1;
          end
          if (bit_last) begin
            cnt_d   = '0;
            index_d = index_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Output is registered, so it is computed from the next-cycle state and index.
    if (state_d == S_RUN) serial_d = act_pattern_d[index_d];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      act_pattern_q <= '0;
      act_freq_q    <= '0;
      act_mode_q    <= 1'b0;
      shd_pattern_q <= '0;
      shd_freq_q    <= '0;
      shd_mode_q    <= 1'b0;
      pending_q     <= 1'b0;
      index_q       <= '0;
      cnt_q         <= '0;
      serial_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      act_pattern_q <= act_pattern_d;
      act_freq_q    <= act_freq_d;
      act_mode_q    <= act_mode_d;
      shd_pattern_q <= shd_pattern_d;
      shd_freq_q    <= shd_freq_d;
      shd_mode_q    <= shd_mode_d;
      pending_q     <= pending_d;
      index_q       <= index_d;
      cnt_q         <= cnt_d;
      serial_q      <= serial_d;
    end
  end

  assign o_serial    = serial_q;
  assign o_busy      = (state_q == S_RUN);
  assign o_bit_index = (state_q == S_RUN) ? index_q : '0;
  assign o_done_tick = (state_q == S_DONE);

endmodule

// File: tb/tb_diff_freq_serial_tx.sv
// tb/tb_diff_freq_serial_tx.sv - scoreboard bench for diff_freq_serial_tx
module tb_diff_freq_serial_tx;

  localparam int DATA_BIT   = 8;
  localparam int FAST_DIV   = 2;
  localparam int SLOW_DIV   = 4;
  localparam int CHANNEL_ID = 1;

  logic       clk;
  logic       rst_n;
  logic       i_load_tick;
  logic [7:0] i_output_pattern;
  logic [7:0] i_freq_pattern;
  logic [3:0] i_sel_out;
  logic       i_start;
  logic       i_stop;
  logic       i_mode;
  logic       o_serial;
  logic       o_busy;
  logic [2:0] o_bit_index;
  logic       o_done_tick;

  // Expected per-cycle output vector: {serial, busy, bit_index[2:0], done}
  logic [5:0] sb[$];
  logic [5:0] exp_v;
  logic [5:0] got_v;
  int         vectors;
  int         miscompares;

  diff_freq_serial_tx #(
    .DATA_BIT  (DATA_BIT),
    .FAST_DIV  (FAST_DIV),
    .SLOW_DIV  (SLOW_DIV),
    .CHANNEL_ID(CHANNEL_ID)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_load_tick     (i_load_tick),
    .i_output_pattern(i_output_pattern),
    .i_freq_pattern  (i_freq_pattern),
    .i_sel_out       (i_sel_out),
    .i_start         (i_start),
    .i_stop          (i_stop),
    .i_mode          (i_mode),
    .o_serial        (o_serial),
    .o_busy          (o_busy),
    .o_bit_index     (o_bit_index),
    .o_done_tick     (o_done_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    i_load_tick      = 1'b0;
    i_output_pattern = 8'h00;
    i_freq_pattern   = 8'h00;
    i_sel_out        = 4'd0;
    i_start          = 1'b0;
    i_stop           = 1'b0;
    i_mode           = 1'b0;
  endtask

  task automatic drive_cmd(input logic [3:0] sel, input logic [7:0] pat, input logic [7:0] freq,
                           input logic start, input logic stop, input logic mode);
    i_load_tick      = 1'b1;
    i_sel_out        = sel;
    i_output_pattern = pat;
    i_freq_pattern   = freq;
    i_start          = start;
    i_stop           = stop;
    i_mode           = mode;
  endtask

  task automatic push_frame(input logic [7:0] pat, input logic [7:0] freq);
    for (int b = 0; b < DATA_BIT; b++) begin
      int per;
      per = freq[b] ? FAST_DIV : SLOW_DIV;
      for (int c = 0; c < per; c++) sb.push_back({pat[b], 1'b1, 3'(b), 1'b0});
    end
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) sb.push_back(6'b000000);
  endtask

  task automatic push_done();
    sb.push_back(6'b000001);
  endtask

  task automatic truncate_sb(input int n);
    while (sb.size() > n) sb.delete(sb.size() - 1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_cmd(4'd1, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      got_v = {o_serial, o_busy, o_bit_index, o_done_tick};
      vectors++;
      if (got_v !== 6'b000000) begin
        miscompares++;
        $display("FAIL reset k=%0d got=%b exp=%b", k, got_v, 6'b000000);
      end
    end
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_one_shot();
    int k;
    k = 0;
    drive_cmd(4'd1, 8'hA5, 8'h0F, 1'b1, 1'b0, 1'b0);
    push_frame(8'hA5, 8'h0F);
    push_done();
    push_idle(2);
    while (sb.size() > 0) begin
      @(negedge clk);
      idle_inputs();
      exp_v = sb.pop_front();
      got_v = {o_serial, o_busy, o_bit_index, o_done_tick};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL one_shot k=%0d got=%b exp=%b", k, got_v, exp_v);
      end
      k++;
    end
  endtask

  task automatic test_channel_filter();
    int k;
    k = 0;
    drive_cmd(4'd2, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
    push_idle(6);
    while (sb.size() > 0) begin
      @(negedge clk);
      idle_inputs();
      exp_v = sb.pop_front();
      got_v = {o_serial, o_busy, o_bit_index, o_done_tick};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL channel_filter k=%0d got=%b exp=%b", k, got_v, exp_v);
      end
      k++;
    end
  endtask

  task automatic test_continuous_update();
    int k;
    k = 0;
    drive_cmd(4'd1, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
    push_frame(8'hFF, 8'hFF);
    push_frame(8'h00, 8'hFF);
    push_done();
    push_idle(2);
    while (sb.size() > 0) begin
      @(negedge clk);
      idle_inputs();
      exp_v = sb.pop_front();
      got_v = {o_serial, o_busy, o_bit_index, o_done_tick};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL continuous k=%0d got=%b exp=%b", k, got_v, exp_v);
      end
      if (k == 5) drive_cmd(4'd1, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
      k++;
    end
  endtask

  task automatic test_stop();
    int k;
    k = 0;
    drive_cmd(4'd1, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
    push_frame(8'hFF, 8'hFF);
    truncate_sb(7);
    push_idle(3);
    push_frame(8'h3C, 8'hAA);
    push_done();
    push_idle(2);
    while (sb.size() > 0) begin
      @(negedge clk);
      idle_inputs();
      exp_v = sb.pop_front();
      got_v = {o_serial, o_busy, o_bit_index, o_done_tick};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL stop k=%0d got=%b exp=%b", k, got_v, exp_v);
      end
      if (k == 2) drive_cmd(4'd1, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b1);
      if (k == 6) drive_cmd(4'd1, 8'hAA, 8'hFF, 1'b1, 1'b1, 1'b1);
      if (k == 9) drive_cmd(4'd1, 8'h3C, 8'hAA, 1'b1, 1'b0, 1'b0);
      k++;
    end
  endtask

  task automatic test_armed_start();
    int k;
    k = 0;
    drive_cmd(4'd1, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0);
    push_idle(11);
    push_frame(8'h80, 8'h00);
    push_done();
    push_idle(2);
    while (sb.size() > 0) begin
      @(negedge clk);
      idle_inputs();
      exp_v = sb.pop_front();
      got_v = {o_serial, o_busy, o_bit_index, o_done_tick};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL armed_start k=%0d got=%b exp=%b", k, got_v, exp_v);
      end
      if (k == 10) drive_cmd(4'd1, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0);
      k++;
    end
  endtask

  task automatic test_back_to_back();
    int k;
    k = 0;
    drive_cmd(4'd1, 8'h0F, 8'hFF, 1'b1, 1'b0, 1'b0);
    push_frame(8'h0F, 8'hFF);
    push_frame(8'hF0, 8'hFF);
    push_done();
    push_idle(2);
    while (sb.size() > 0) begin
      @(negedge clk);
      idle_inputs();
      exp_v = sb.pop_front();
      got_v = {o_serial, o_busy, o_bit_index, o_done_tick};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL back_to_back k=%0d got=%b exp=%b", k, got_v, exp_v);
      end
      if (k == 15) drive_cmd(4'd1, 8'hF0, 8'hFF, 1'b1, 1'b0, 1'b0);
      k++;
    end
  endtask

  task automatic test_reset_mid_frame();
    int k;
    k = 0;
    drive_cmd(4'd1, 8'hA5, 8'hFF, 1'b1, 1'b0, 1'b1);
    push_frame(8'hA5, 8'hFF);
    truncate_sb(11);
    push_idle(2);
    push_frame(8'h5A, 8'hF0);
    push_done();
    push_idle(2);
    while (sb.size() > 0) begin
      @(negedge clk);
      idle_inputs();
      exp_v = sb.pop_front();
      got_v = {o_serial, o_busy, o_bit_index, o_done_tick};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL reset_mid_frame k=%0d got=%b exp=%b", k, got_v, exp_v);
      end
      if (k == 10) rst_n = 1'b0;
      if (k == 11) rst_n = 1'b1;
      if (k == 12) drive_cmd(4'd1, 8'h5A, 8'hF0, 1'b1, 1'b0, 1'b0);
      k++;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    idle_inputs();
    test_reset();
    test_one_shot();
    test_channel_filter();
    test_continuous_update();
    test_stop();
    test_armed_start();
    test_back_to_back();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the run completed");
    $fatal(1, "watchdog");
  end

endmodule
